// File: rtl/vga_pkg.sv
// Shared constants, encodings and colour helpers for the VGA pixel fetch path.
package vga_pkg;

    localparam int VGA_HDATA  = 800;
    localparam int VGA_VDATA  = 600;
    localparam int VGA_ADDR_W = 19;
    localparam int VGA_BAR_W  = 100;

    typedef enum logic [1:0] {
        PAT_MEM   = 2'd0,
        PAT_BARS  = 2'd1,
        PAT_SOLID = 2'd2,
        PAT_RAMP  = 2'd3
    } pat_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DRAIN0 = 2'd2,
        ST_DRAIN1 = 2'd3
    } state_e;

    localparam logic [8:0] BAR_WHITE   = 9'h1FF;
    localparam logic [8:0] BAR_YELLOW  = 9'h1F8;
    localparam logic [8:0] BAR_CYAN    = 9'h03F;
    localparam logic [8:0] BAR_GREEN   = 9'h038;
    localparam logic [8:0] BAR_MAGENTA = 9'h1C7;
    localparam logic [8:0] BAR_RED     = 9'h1C0;
    localparam logic [8:0] BAR_BLUE    = 9'h007;
    localparam logic [8:0] BAR_BLACK   = 9'h000;

    function automatic logic [8:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/vga_pat_gen.sv
// Test-pattern source: picks a pattern pixel and delays it two cycles so it
// lines up with a memory word read one cycle earlier and then registered.
module vga_pat_gen
    import vga_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear_i,
    input  logic       valid_i,
    input  pat_sel_e   mode_i,
    input  logic [8:0] x_i,
    input  logic [2:0] bar_idx_i,
    input  logic [8:0] solid_i,
    output logic [8:0] pix_o
);

    logic [8:0] pat_d;
    logic [8:0] pipe0_q;
    logic [8:0] pipe1_q;

    always_comb begin
        pat_d = '0;
        if (valid_i) begin
            case (mode_i)
                PAT_BARS:  pat_d = bar_color(bar_idx_i);
                PAT_SOLID: pat_d = solid_i;
                PAT_RAMP:  pat_d = x_i;
                default:   pat_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe0_q <= '0;
            pipe1_q <= '0;
        end else if (clear_i) begin
            pipe0_q <= '0;
            pipe1_q <= '0;
        end else begin
            pipe0_q <= pat_d;
            pipe1_q <= pipe0_q;
        end
    end

    assign pix_o = pipe1_q;

endmodule

// File: rtl/vga_pix_fetch.sv
// Per-line pixel streamer feeding the VGA timing controller from frame memory
// or a built-in test pattern, with line tracking and vsync resynchronisation.
module vga_pix_fetch
    import vga_pkg::*;
#(
    parameter int P_HDATA  = VGA_HDATA,
    parameter int P_VDATA  = VGA_VDATA,
    parameter int P_ADDR_W = VGA_ADDR_W,
    parameter int P_BAR_W  = VGA_BAR_W
) (
    input  logic                CLK_40M,
    input  logic                SYS_RST_N,
    input  logic                REG_VGA_EN,
    input  logic [1:0]          REG_PAT_SEL,
    input  logic [8:0]          REG_SOLID_COLOR,
    input  logic [P_ADDR_W-1:0] REG_FB_BASE,
    input  logic                VGA_REQ,
    input  logic                VGA_VSYNC,
    output logic                MEM_RD_EN,
    output logic [P_ADDR_W-1:0] MEM_RD_ADDR,
    input  logic [15:0]         MEM_RD_DATA,
    output logic [15:0]         SLCT_OUT_DATA,
    output logic                FETCH_ERR
);

    localparam int X_W = $clog2(P_HDATA);
    localparam int L_W = $clog2(P_VDATA);
    localparam int B_W = $clog2(P_BAR_W);

    localparam logic [X_W-1:0] X_LAST   = X_W'(P_HDATA - 1);
    localparam logic [L_W-1:0] L_LAST   = L_W'(P_VDATA - 1);
    localparam logic [B_W-1:0] BAR_LAST = B_W'(P_BAR_W - 1);

    state_e              state_q,     state_d;
    logic [X_W-1:0]      x_q,         x_d;
    logic [L_W-1:0]      line_q,      line_d;
    logic [P_ADDR_W-1:0] line_base_q, line_base_d;
    pat_sel_e            mode_q,      mode_d;
    logic [8:0]          solid_q,     solid_d;
    logic [P_ADDR_W-1:0] base_q,      base_d;
    logic [B_W-1:0]      bar_cnt_q,   bar_cnt_d;
    logic [2:0]          bar_idx_q,   bar_idx_d;
    logic                vs_prev_q,   vs_prev_d;
    logic                err_q,       err_d;
    logic                mem_v_q,     mem_v_d;
    logic [15:0]         mem_out_q,   mem_out_d;

    logic       accept;
    logic       fetching;
    logic       line_done;
    logic       vs_rise;
    logic [8:0] pat_pix;

    assign accept    = VGA_REQ && REG_VGA_EN && (state_q == ST_IDLE);
    assign fetching  = (state_q == ST_FETCH);
    assign line_done = fetching && (x_q == X_LAST);
    assign vs_rise   = VGA_VSYNC && !vs_prev_q;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        line_d      = line_q;
        line_base_d = line_base_q;
        mode_d      = mode_q;
        solid_d     = solid_q;
        base_d      = base_q;
        bar_cnt_d   = bar_cnt_q;
        bar_idx_d   = bar_idx_q;
        vs_prev_d   = VGA_VSYNC;
        err_d       = VGA_REQ && REG_VGA_EN && (state_q != ST_IDLE);
        mem_v_d     = fetching && (mode_q == PAT_MEM);
        mem_out_d   = mem_v_q ? MEM_RD_DATA : 16'h0000;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_FETCH;
                    x_d       = '0;
                    bar_cnt_d = '0;
                    bar_idx_d = '0;
                    mode_d    = pat_sel_e'(REG_PAT_SEL);
                    solid_d   = REG_SOLID_COLOR;
                    base_d    = REG_FB_BASE;
                end
            end
            ST_FETCH: begin
                x_d = x_q + X_W'(1);
                if (bar_cnt_q == BAR_LAST) begin
                    bar_cnt_d = '0;
                    bar_idx_d = bar_idx_q + 3'd1;
                end else begin
                    bar_cnt_d = bar_cnt_q + B_W'(1);
                end
                if (line_done) begin
                    state_d = ST_DRAIN0;
                    x_d     = '0;
                end
            end
            ST_DRAIN0: state_d = ST_DRAIN1;
            default:   state_d = ST_IDLE;
        endcase

        if (line_done) begin
            if (line_q == L_LAST) begin
                line_d      = '0;
                line_base_d = '0;
            end else begin
                line_d      = line_q + L_W'(1);
                line_base_d = line_base_q + P_ADDR_W'(P_HDATA);
            end
        end

        // A frame start overrides any line completion landing in the same cycle.
        if (vs_rise) begin
            line_d      = '0;
            line_base_d = '0;
        end

        if (!REG_VGA_EN) begin
            state_d     = ST_IDLE;
            x_d         = '0;
            line_d      = '0;
            line_base_d = '0;
            bar_cnt_d   = '0;
            bar_idx_d   = '0;
            err_d       = 1'b0;
            mem_v_d     = 1'b0;
            mem_out_d   = 16'h0000;
        end
    end

    always_ff @(posedge CLK_40M or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            line_q      <= '0;
            line_base_q <= '0;
            mode_q      <= PAT_MEM;
            solid_q     <= '0;
            base_q      <= '0;
            bar_cnt_q   <= '0;
            bar_idx_q   <= '0;
            vs_prev_q   <= 1'b0;
            err_q       <= 1'b0;
            mem_v_q     <= 1'b0;
            mem_out_q   <= 16'h0000;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            line_q      <= line_d;
            line_base_q <= line_base_d;
            mode_q      <= mode_d;
            solid_q     <= solid_d;
            base_q      <= base_d;
            bar_cnt_q   <= bar_cnt_d;
            bar_idx_q   <= bar_idx_d;
            vs_prev_q   <= vs_prev_d;
            err_q       <= err_d;
            mem_v_q     <= mem_v_d;
            mem_out_q   <= mem_out_d;
        end
    end

    vga_pat_gen u_pat_gen (
        .clk_i     (CLK_40M),
        .rst_ni    (SYS_RST_N),
        .clear_i   (!REG_VGA_EN),
        .valid_i   (fetching && (mode_q != PAT_MEM)),
        .mode_i    (mode_q),
        .x_i       (9'(x_q)),
        .bar_idx_i (bar_idx_q),
        .solid_i   (solid_q),
        .pix_o     (pat_pix)
    );

    assign MEM_RD_EN     = fetching && (mode_q == PAT_MEM);
    assign MEM_RD_ADDR   = MEM_RD_EN ? (base_q + line_base_q + P_ADDR_W'(x_q)) : '0;
    assign SLCT_OUT_DATA = mem_out_q | {7'd0, pat_pix};
    assign FETCH_ERR     = err_q;

endmodule

// File: tb/tb_vga_pix_fetch.sv
// Directed bench for vga_pix_fetch: memory/pattern lines, line tracking,
// vsync resync, overlapping requests and enable drop, against hand-derived values.
module tb_vga_pix_fetch;

    localparam int HDATA  = 800;
    localparam int VDATA  = 4;
    localparam int ADDR_W = 19;
    localparam int BAR_W  = 100;

    logic              CLK_40M = 1'b0;
    logic              SYS_RST_N;
    logic              REG_VGA_EN;
    logic [1:0]        REG_PAT_SEL;
    logic [8:0]        REG_SOLID_COLOR;
    logic [ADDR_W-1:0] REG_FB_BASE;
    logic              VGA_REQ;
    logic              VGA_VSYNC;
    logic              MEM_RD_EN;
    logic [ADDR_W-1:0] MEM_RD_ADDR;
    logic [15:0]       MEM_RD_DATA;
    logic [15:0]       SLCT_OUT_DATA;
    logic              FETCH_ERR;

    int nCompared   = 0;
    int nMismatched = 0;
    int expLine     = 0;

    logic [8:0] barColor [8] = '{9'h1FF, 9'h1F8, 9'h03F, 9'h038, 9'h1C7, 9'h1C0, 9'h007, 9'h000};

    always #5 CLK_40M = ~CLK_40M;

    vga_pix_fetch #(
        .P_HDATA  (HDATA),
        .P_VDATA  (VDATA),
        .P_ADDR_W (ADDR_W),
        .P_BAR_W  (BAR_W)
    ) dut (
        .CLK_40M         (CLK_40M),
        .SYS_RST_N       (SYS_RST_N),
        .REG_VGA_EN      (REG_VGA_EN),
        .REG_PAT_SEL     (REG_PAT_SEL),
        .REG_SOLID_COLOR (REG_SOLID_COLOR),
        .REG_FB_BASE     (REG_FB_BASE),
        .VGA_REQ         (VGA_REQ),
        .VGA_VSYNC       (VGA_VSYNC),
        .MEM_RD_EN       (MEM_RD_EN),
        .MEM_RD_ADDR     (MEM_RD_ADDR),
        .MEM_RD_DATA     (MEM_RD_DATA),
        .SLCT_OUT_DATA   (SLCT_OUT_DATA),
        .FETCH_ERR       (FETCH_ERR)
    );

    // Frame memory returns its own address; a junk word when not strobed.
    always @(posedge CLK_40M)
        MEM_RD_DATA <= MEM_RD_EN ? MEM_RD_ADDR[15:0] : 16'hBEEF;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK_40M);
        #1;
    endtask

    function automatic logic [15:0] expPixel(input int mode, input int n, input logic [ADDR_W-1:0] base,
                                             input logic [8:0] solid);
        logic [ADDR_W-1:0] a;
        logic [8:0]        r;
        case (mode)
            0: begin
                a = base + ADDR_W'(n);
                return a[15:0];
            end
            1: return {7'd0, barColor[n / BAR_W]};
            2: return {7'd0, solid};
            default: begin
                r = 9'(n);
                return {7'd0, r};
            end
        endcase
    endfunction

    // One line: request at k=0, then every cycle through R+804 is checked.
    task automatic applyStimulus(input int mode, input int reqAgainAt, input int disableAt, input int solidChangeAt);
        logic [ADDR_W-1:0] lineBase;
        logic [ADDR_W-1:0] expAddr;
        logic [8:0]        latchedSolid;
        logic [15:0]       expOut;
        bit                expEn;
        bit                expErr;
        bit                dead;
        lineBase     = REG_FB_BASE + ADDR_W'(expLine * HDATA);
        latchedSolid = REG_SOLID_COLOR;
        REG_PAT_SEL  = 2'(mode);
        for (int k = 0; k <= HDATA + 4; k++) begin
            VGA_REQ = (k == 0) || (k == reqAgainAt);
            if (k == disableAt) REG_VGA_EN = 1'b0;
            if (k == solidChangeAt) REG_SOLID_COLOR = 9'h111;
            dead   = (disableAt >= 0) && (k > disableAt);
            expOut = (!dead && k >= 3 && k <= HDATA + 2) ? expPixel(mode, k - 3, lineBase, latchedSolid) : 16'h0000;
            expEn  = !dead && (mode == 0) && k >= 1 && k <= HDATA;
            expErr = (reqAgainAt >= 0) && (k == reqAgainAt + 1);
            checkOutput($sformatf("m%0d L%0d pix k=%0d", mode, expLine, k), 32'(SLCT_OUT_DATA), 32'(expOut));
            checkOutput($sformatf("m%0d L%0d rd_en k=%0d", mode, expLine, k), 32'(MEM_RD_EN), 32'(expEn));
            checkOutput($sformatf("m%0d L%0d err k=%0d", mode, expLine, k), 32'(FETCH_ERR), 32'(expErr));
            if (expEn) begin
                expAddr = lineBase + ADDR_W'(k - 1);
                checkOutput($sformatf("m%0d L%0d addr k=%0d", mode, expLine, k), 32'(MEM_RD_ADDR), 32'(expAddr));
            end
            tick();
        end
        VGA_REQ = 1'b0;
        if (disableAt >= 0) expLine = 0;
        else expLine = (expLine + 1) % VDATA;
    endtask

    task automatic pulseVsync();
        VGA_VSYNC = 1'b1;
        repeat (2) tick();
        VGA_VSYNC = 1'b0;
        tick();
        expLine = 0;
    endtask

    initial begin
        SYS_RST_N       = 1'b0;
        REG_VGA_EN      = 1'b1;
        REG_PAT_SEL     = 2'd0;
        REG_SOLID_COLOR = 9'h000;
        REG_FB_BASE     = '0;
        VGA_REQ         = 1'b0;
        VGA_VSYNC       = 1'b0;
        repeat (3) tick();

        checkOutput("reset pix", 32'(SLCT_OUT_DATA), 32'h0);
        checkOutput("reset rd_en", 32'(MEM_RD_EN), 32'h0);
        checkOutput("reset addr", 32'(MEM_RD_ADDR), 32'h0);
        checkOutput("reset err", 32'(FETCH_ERR), 32'h0);

        SYS_RST_N = 1'b1;
        tick();

        $display("[TB] memory lines 0..2");
        repeat (3) applyStimulus(0, -1, -1, -1);

        $display("[TB] vsync resync");
        pulseVsync();
        applyStimulus(0, -1, -1, -1);

        $display("[TB] colour bars, solid, ramp");
        applyStimulus(1, -1, -1, -1);
        REG_SOLID_COLOR = 9'h0A5;
        applyStimulus(2, -1, -1, 400);
        applyStimulus(2, -1, -1, -1);
        applyStimulus(3, -1, -1, -1);

        $display("[TB] request during streaming");
        applyStimulus(0, 400, -1, -1);

        $display("[TB] enable drop mid-line");
        applyStimulus(0, -1, 200, -1);
        REG_VGA_EN = 1'b1;
        tick();
        applyStimulus(0, -1, -1, -1);

        $display("[TB] frame wrap with high base address");
        REG_FB_BASE = 19'h7FF00;
        repeat (VDATA) applyStimulus(0, -1, -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/vga_pix_fetch.md
Name: vga_pix_fetch

Overview:
- Pixel source directly upstream of the VGA timing controller.
- On each per-line request pulse it streams P_HDATA pixels into the controller's 16-bit pixel input, aligned to the controller's fixed 3-cycle request-to-data slot.
- Pixels come from a synchronous-read frame memory (1-cycle read latency) or from a built-in test pattern.
- Tracks line position within the frame and resynchronises on vertical sync.

Parameters:
- P_HDATA, 800, active pixels per line
- P_VDATA, 600, active lines per frame
- P_ADDR_W, 19, frame memory word-address width
- P_BAR_W, 100, colour-bar width in pixels (P_HDATA = 8*P_BAR_W)

Ports:
- CLK_40M  in  1  pixel clock 40 MHz
- SYS_RST_N  in  1  asynchronous active-low reset
- REG_VGA_EN  in  1  global enable; low = idle, counters cleared
- REG_PAT_SEL  in  2  0 = memory, 1 = colour bars, 2 = solid colour, 3 = horizontal ramp
- REG_SOLID_COLOR  in  9  RGB333 colour for mode 2
- REG_FB_BASE  in  P_ADDR_W  frame buffer base word address
- VGA_REQ  in  1  one-cycle line request from the timing controller
- VGA_VSYNC  in  1  vertical sync from the timing controller, active high
- MEM_RD_EN  out  1  memory read strobe
- MEM_RD_ADDR  out  P_ADDR_W  memory word address
- MEM_RD_DATA  in  16  read data, valid the cycle after MEM_RD_EN
- SLCT_OUT_DATA  out  16  pixel to controller; bits [8:0] are RGB333 (R = [8:6])
- FETCH_ERR  out  1  one-cycle pulse: request arrived while a line was still streaming

Behaviour:
- Reset values: all outputs 0, state IDLE, x = 0, line = 0, line_base = 0.
- Timing contract:
  - Let cycle R be the cycle in which VGA_REQ = 1.
  - Pixel n (n = 0..P_HDATA-1) is on SLCT_OUT_DATA during cycle R+3+n.
  - SLCT_OUT_DATA = 0 in every other cycle.
- State machine:
  - IDLE -> FETCH on VGA_REQ && REG_VGA_EN.
  - FETCH spans R+1 .. R+P_HDATA. The x counter runs 0..P_HDATA-1.
  - FETCH -> DRAIN when x = P_HDATA-1.
  - DRAIN lasts 2 cycles, emptying the memory/output pipeline, then returns to IDLE.
- Memory mode:
  - MEM_RD_EN = 1 throughout FETCH.
  - MEM_RD_ADDR = REG_FB_BASE + line_base + x, truncated modulo 2^P_ADDR_W.
  - MEM_RD_DATA is registered into SLCT_OUT_DATA one cycle after arrival.
- Pattern modes:
  - MEM_RD_EN = 0.
  - Pattern value enters a matching 2-stage delay so alignment is identical to memory mode; upper bits [15:9] = 0.
- Colour bars:
  - Bar index comes from a bar counter that wraps at P_BAR_W (no divider).
  - Bar colours in order: 1FF, 1F8, 03F, 038, 1C7, 1C0, 007, 000.
- Solid: REG_SOLID_COLOR. Ramp: x[8:0].
- REG_PAT_SEL, REG_SOLID_COLOR and REG_FB_BASE are latched on request acceptance and held constant for the whole line.
- Line tracking:
  - On FETCH -> DRAIN, line increments and line_base += P_HDATA.
  - When line reaches P_VDATA-1 and completes, both wrap to 0.
- Frame resync:
  - The rising edge of VGA_VSYNC is detected with a registered previous value.
  - It clears line and line_base to 0 in the next cycle.
  - If it coincides with a line completion, the clear wins.
- Request while not IDLE (FETCH or DRAIN):
  - The request is ignored and the current line completes unchanged.
  - FETCH_ERR pulses 1 cycle, in cycle R+1.
- REG_VGA_EN low:
  - Takes effect at the next edge: state forced to IDLE, pipeline and outputs zeroed, line and line_base cleared.
  - Requests are ignored while REG_VGA_EN is low.
- Asynchronous reset mid-line: all state returns to reset values immediately; the next accepted request starts line 0.

Decomposition:
- Shared package vga_pkg: timing constants (P_HDATA, P_VDATA), RGB333 colour-bar constants, PAT_SEL encodings, state encoding.
- One sub-module, vga_pat_gen: combinational pattern value from mode, x, bar index and solid colour, plus its 2-stage alignment pipe.

Test Plan:
- Reset, then release SYS_RST_N; memory model returns data = address[15:0]; REG_FB_BASE = 0; REG_PAT_SEL = 0; pulse VGA_REQ at cycle R -> SLCT_OUT_DATA = 0..799 during R+3..R+802, 0 at R+2 and R+803; MEM_RD_EN high exactly during R+1..R+800.
- Two further requests (>= 803 cycles apart) -> second line data 800..1599, third line 1600..2399; then VGA_VSYNC rising edge, next request -> data restarts at 0.
- REG_PAT_SEL = 1 -> pixels 0..99 = 0x1FF, 100..199 = 0x1F8, ..., 700..799 = 0x000; MEM_RD_EN stays 0.
- REG_PAT_SEL = 2, REG_SOLID_COLOR = 0x0A5, change REG_SOLID_COLOR to 0x111 mid-line -> all 800 pixels = 0x0A5; next line all = 0x111.
- Second VGA_REQ at R+400 -> FETCH_ERR = 1 at R+401 only; first line output unaffected.
- REG_VGA_EN drops at R+200 -> SLCT_OUT_DATA = 0 from R+201; next request after re-enable outputs line 0 addresses; run 600 lines without vsync -> line 601 wraps to address REG_FB_BASE + 0.
